cmlink_rx_align_ctrl: RTL and testbench

Word-alignment controller for the Camera Link receive deserializer. It sequences deserializer bring-up: holds io_reset, releases clock_enable and waits for settle. It then issues bitslip pulses until the deserialized forwarded-clock lane shows the Camera Link frame pattern, and declares lock. In LOCKED it monitors the pattern and re-aligns after a burst of errors. It sits between the SelectIO receive wrapper and `cmlink2dcp`, running in the divided (pixel) clock domain.

---
 rtl/cmlink_pkg.sv | 38 +++
 rtl/cmlink_rx_align_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cmlink_rx_align_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmlink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmlink_pkg
//  Description : Shared types and constants for the Camera Link receive path:
//                lane geometry, forwarded-clock frame pattern and the
//                word-alignment FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmlink_pkg;

    // Number of data lanes and bits per deserialized word
    localparam int CMLINK_LANES = 4;
    localparam int CMLINK_BITS  = 7;

    // Forwarded-clock lane word once correctly framed (4 high, 3 low)
    localparam logic [CMLINK_BITS-1:0] CMLINK_CLK_PATTERN = 7'b1100011;

    // Word-alignment controller states
    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CHECK     = 3'd2,
        ST_SLIP      = 3'd3,
        ST_SLIP_WAIT = 3'd4,
        ST_LOCKED    = 3'd5
    } align_state_t;

    // Largest of three counts; sizes the shared phase counter
    function automatic int cmlink_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage : cmlink_pkg
`default_nettype wire

// File: rtl/cmlink_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cmlink_rx_align_ctrl
//  Description : Camera Link receive word-alignment controller. Sequences the
//                deserializer out of io_reset, then bitslips all lanes until
//                the forwarded-clock lane shows the frame pattern, declares
//                lock and re-aligns after a burst of pattern errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmlink_rx_align_ctrl
    import cmlink_pkg::*;
#(
    parameter int                      RST_CYCLES    = 16,
    parameter int                      SETTLE_CYCLES = 8,
    parameter int                      SLIP_WAIT     = 4,
    parameter int                      LOCK_MATCHES  = 16,
    parameter int                      ERR_THRESH    = 4,
    parameter int                      MAX_SLIPS     = 14,
    parameter logic [CMLINK_BITS-1:0]  CLK_PATTERN   = CMLINK_CLK_PATTERN
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [CMLINK_BITS-1:0] i_clk_word,
    input  logic                   i_relock,
    output logic                   o_io_reset,
    output logic                   o_clock_enable,
    output logic [CMLINK_LANES:0]  o_bitslip,
    output logic                   o_locked,
    output logic                   o_align_err,
    output logic [7:0]             o_slip_cnt
);

    // Shared phase counter covers reset hold, settle and post-slip wait
    localparam int CNT_MAX = cmlink_max3(RST_CYCLES, SETTLE_CYCLES, SLIP_WAIT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int ERR_W   = $clog2(ERR_THRESH + 1);

    // Terminal values: each phase counts 0 .. N-1
    localparam logic [CNT_W-1:0]   C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_WAIT_LAST   = CNT_W'(SLIP_WAIT - 1);
    localparam logic [MATCH_W-1:0] C_MATCH_LAST  = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [ERR_W-1:0]   C_ERR_LAST    = ERR_W'(ERR_THRESH - 1);
    localparam logic [7:0]         C_MAX_SLIPS   = 8'((MAX_SLIPS > 255) ? 255 : MAX_SLIPS);

    align_state_t       r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [7:0]         r_slip_cnt;
    logic               r_io_reset;
    logic               r_clock_enable;
    logic               r_slip;
    logic               r_locked;
    logic               r_align_err;

    logic               w_match;
    logic [7:0]         w_slip_next;

    // Frame-pattern comparator on the forwarded-clock lane
    assign w_match = (i_clk_word == CLK_PATTERN);

    // Saturating next value of the slip counter
    assign w_slip_next = (r_slip_cnt == 8'hFF) ? 8'hFF : (r_slip_cnt + 8'd1);

    // Alignment FSM with its counters and registered outputs.
    // Slip count and bitslip pulse are updated on entry to SLIP so that the
    // registered pulse and count are visible during the SLIP cycle itself.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state        <= ST_RST_HOLD;
            r_cnt          <= '0;
            r_match_cnt    <= '0;
            r_err_cnt      <= '0;
            r_slip_cnt     <= 8'd0;
            r_io_reset     <= 1'b1;
            r_clock_enable <= 1'b0;
            r_slip         <= 1'b0;
            r_locked       <= 1'b0;
            r_align_err    <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            if (i_relock) begin
                // Restart bring-up; slip history and error flag are kept
                r_state        <= ST_RST_HOLD;
                r_cnt          <= '0;
                r_match_cnt    <= '0;
                r_err_cnt      <= '0;
                r_io_reset     <= 1'b1;
                r_clock_enable <= 1'b0;
                r_locked       <= 1'b0;
            end else begin
                case (r_state)
                    ST_RST_HOLD: begin
                        if (r_cnt == C_RST_LAST) begin
                            r_state        <= ST_SETTLE;
                            r_cnt          <= '0;
                            r_io_reset     <= 1'b0;
                            r_clock_enable <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    ST_SETTLE: begin
                        if (r_cnt == C_SETTLE_LAST) begin
                            r_state     <= ST_CHECK;
                            r_cnt       <= '0;
                            r_match_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    ST_CHECK: begin
                        if (w_match) begin
                            if (r_match_cnt == C_MATCH_LAST) begin
                                r_state     <= ST_LOCKED;
                                r_match_cnt <= '0;
                                r_err_cnt   <= '0;
                                r_locked    <= 1'b1;
                                r_slip_cnt  <= 8'd0;
                                r_align_err <= 1'b0;
                            end else begin
                                r_match_cnt <= r_match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            r_state     <= ST_SLIP;
                            r_match_cnt <= '0;
                            r_slip      <= 1'b1;
                            r_slip_cnt  <= w_slip_next;
                            if (w_slip_next >= C_MAX_SLIPS) begin
                                r_align_err <= 1'b1;
                            end
                        end
                    end

                    ST_SLIP: begin
                        r_state <= ST_SLIP_WAIT;
                        r_cnt   <= '0;
                    end

                    ST_SLIP_WAIT: begin
                        // Deserializer output is in flux here; word ignored
                        if (r_cnt == C_WAIT_LAST) begin
                            r_state     <= ST_CHECK;
                            r_cnt       <= '0;
                            r_match_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    ST_LOCKED: begin
                        if (w_match) begin
                            r_err_cnt <= '0;
                        end else if (r_err_cnt == C_ERR_LAST) begin
                            r_state     <= ST_CHECK;
                            r_cnt       <= '0;
                            r_match_cnt <= '0;
                            r_err_cnt   <= '0;
                            r_locked    <= 1'b0;
                        end else begin
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                    end

                    default: begin
                        r_state        <= ST_RST_HOLD;
                        r_cnt          <= '0;
                        r_match_cnt    <= '0;
                        r_err_cnt      <= '0;
                        r_io_reset     <= 1'b1;
                        r_clock_enable <= 1'b0;
                        r_locked       <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Registered outputs; one slip pulse drives every lane's bitslip
    assign o_io_reset     = r_io_reset;
    assign o_clock_enable = r_clock_enable;
    assign o_bitslip      = {(CMLINK_LANES + 1){r_slip}};
    assign o_locked       = r_locked;
    assign o_align_err    = r_align_err;
    assign o_slip_cnt     = r_slip_cnt;

endmodule : cmlink_rx_align_ctrl
`default_nettype wire

// File: tb/tb_cmlink_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmlink_rx_align_ctrl
//  Description : Directed self-checking bench for cmlink_rx_align_ctrl with a
//                small deserializer model that rotates the clock-lane word
//                back by one bit on every bitslip pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmlink_rx_align_ctrl;

    localparam logic [6:0] PAT = 7'b1100011;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] clk_word;
    logic       relock;
    logic       io_reset;
    logic       clock_enable;
    logic [4:0] bitslip;
    logic       locked;
    logic       align_err;
    logic [7:0] slip_cnt;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         pulses = 0;
    int         bad_slip = 0;
    int         pulse_cyc [16];
    int         rot    = 0;
    logic       garbage = 1'b0;
    logic       flip    = 1'b0;

    cmlink_rx_align_ctrl dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_clk_word     (clk_word),
        .i_relock       (relock),
        .o_io_reset     (io_reset),
        .o_clock_enable (clock_enable),
        .o_bitslip      (bitslip),
        .o_locked       (locked),
        .o_align_err    (align_err),
        .o_slip_cnt     (slip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rotl(input logic [6:0] v, input int n);
        logic [6:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
        return r;
    endfunction

    // Deserializer model output
    always_comb begin
        clk_word = rotl(PAT, rot);
        if (flip)    clk_word = ~PAT;
        if (garbage) clk_word = 7'h00;
    end

    // One clock; sample #1 after the edge and apply bitslip to the model
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip != 5'h00) begin
            if (bitslip != 5'h1F) bad_slip++;
            if (pulses < 16) pulse_cyc[pulses] = cyc;
            pulses++;
            rot = (rot == 0) ? 6 : rot - 1;
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn     = 1'b1;
        cyc      = 0;
        pulses   = 0;
        bad_slip = 0;
    endtask

    task automatic run_to_lock(input int budget, output int io_fall, output int lock_cyc,
                               output logic [7:0] pre_cnt);
        io_fall  = -1;
        lock_cyc = -1;
        pre_cnt  = 8'hxx;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (io_fall < 0 && !io_reset) io_fall = cyc;
            if (locked) begin
                lock_cyc = cyc;
                break;
            end
            pre_cnt = slip_cnt;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({io_reset, clock_enable, bitslip, locked, align_err, slip_cnt} !== {1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got=%b exp=%b", {io_reset, clock_enable, bitslip, locked, align_err, slip_cnt},
                     {1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00});
        end
    endtask

    task automatic test_aligned();
        int f, l;
        logic [7:0] pc;
        garbage = 1'b0; flip = 1'b0; rot = 0;
        apply_reset();
        run_to_lock(100, f, l, pc);
        checks++; if (f !== 16) begin errors++; $display("FAIL aligned_io_reset_fall got=%0d exp=16", f); end
        checks++; if (l !== 40) begin errors++; $display("FAIL aligned_lock_cycle got=%0d exp=40", l); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL aligned_pulses got=%0d exp=0", pulses); end
        checks++; if (slip_cnt !== 8'd0) begin errors++; $display("FAIL aligned_slip_cnt got=%0d exp=0", slip_cnt); end
    endtask

    task automatic test_rotated();
        int f, l;
        logic [7:0] pc;
        garbage = 1'b0; flip = 1'b0; rot = 3;
        apply_reset();
        run_to_lock(200, f, l, pc);
        checks++; if (pulses !== 3) begin errors++; $display("FAIL rot_pulses got=%0d exp=3", pulses); end
        checks++; if (pulse_cyc[0] !== 25) begin errors++; $display("FAIL rot_first_pulse got=%0d exp=25", pulse_cyc[0]); end
        checks++; if (pulse_cyc[1] - pulse_cyc[0] !== 6) begin errors++; $display("FAIL rot_spacing1 got=%0d exp=6", pulse_cyc[1] - pulse_cyc[0]); end
        checks++; if (pulse_cyc[2] - pulse_cyc[1] !== 6) begin errors++; $display("FAIL rot_spacing2 got=%0d exp=6", pulse_cyc[2] - pulse_cyc[1]); end
        checks++; if (bad_slip !== 0) begin errors++; $display("FAIL rot_bitslip_bits_equal got=%0d exp=0", bad_slip); end
        checks++; if (l !== 58) begin errors++; $display("FAIL rot_lock_cycle got=%0d exp=58", l); end
        checks++; if (pc !== 8'd3) begin errors++; $display("FAIL rot_slip_cnt_pre got=%0d exp=3", pc); end
        checks++; if (slip_cnt !== 8'd0) begin errors++; $display("FAIL rot_slip_cnt_post got=%0d exp=0", slip_cnt); end
    endtask

    task automatic test_err_inject();
        int f, l, drop, relk;
        logic [7:0] pc;
        garbage = 1'b0; flip = 1'b0; rot = 0;
        apply_reset();
        run_to_lock(100, f, l, pc);
        checks++; if (l !== 40) begin errors++; $display("FAIL inj_initial_lock got=%0d exp=40", l); end
        flip = 1'b1; repeat (3) tick();
        flip = 1'b0; tick();
        flip = 1'b1; repeat (3) tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inj_lock_holds got=%b exp=1", locked); end
        tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL inj_lock_drop got=%b exp=0", locked); end
        flip = 1'b0;
        drop = cyc;
        relk = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (locked) begin relk = cyc - drop; break; end
        end
        checks++; if (relk !== 16) begin errors++; $display("FAIL inj_relock_delay got=%0d exp=16", relk); end
        checks++; if ({io_reset, pulses} !== {1'b0, 32'd0}) begin errors++; $display("FAIL inj_no_reset_no_slip got io_reset=%b pulses=%0d exp 0/0", io_reset, pulses); end
    endtask

    task automatic test_relock();
        int f, l, r, fall, lk;
        logic [7:0] pc;
        garbage = 1'b0; flip = 1'b0; rot = 0;
        apply_reset();
        run_to_lock(100, f, l, pc);
        flip = 1'b1; repeat (3) tick();
        relock = 1'b1;
        tick();
        relock = 1'b0;
        flip   = 1'b0;
        r      = cyc;
        checks++; if ({io_reset, clock_enable, locked} !== 3'b100) begin errors++; $display("FAIL relock_wins got=%b exp=100", {io_reset, clock_enable, locked}); end
        fall = -1; lk = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (fall < 0 && !io_reset) fall = cyc - r;
            if (locked) begin lk = cyc - r; break; end
        end
        checks++; if (fall !== 16) begin errors++; $display("FAIL relock_io_reset_len got=%0d exp=16", fall); end
        checks++; if (lk !== 40) begin errors++; $display("FAIL relock_lock_delay got=%0d exp=40", lk); end
    endtask

    task automatic test_garbage();
        logic       e13, e14, seen_lock;
        logic [7:0] c14;
        garbage = 1'b1; flip = 1'b0; rot = 0;
        apply_reset();
        e13 = 1'bx; e14 = 1'bx; c14 = 8'hxx; seen_lock = 1'b0;
        for (int i = 0; i < 2000 && pulses < 260; i++) begin
            tick();
            if (locked) seen_lock = 1'b1;
            if (bitslip != 5'h00 && pulses == 13) e13 = align_err;
            if (bitslip != 5'h00 && pulses == 14) begin e14 = align_err; c14 = slip_cnt; end
        end
        checks++; if (e13 !== 1'b0) begin errors++; $display("FAIL garb_err_at13 got=%b exp=0", e13); end
        checks++; if (e14 !== 1'b1) begin errors++; $display("FAIL garb_err_at14 got=%b exp=1", e14); end
        checks++; if (c14 !== 8'd14) begin errors++; $display("FAIL garb_cnt_at14 got=%0d exp=14", c14); end
        checks++; if (pulses !== 260) begin errors++; $display("FAIL garb_pulses got=%0d exp=260", pulses); end
        checks++; if (seen_lock !== 1'b0) begin errors++; $display("FAIL garb_never_locked got=%b exp=0", seen_lock); end
        checks++; if (slip_cnt !== 8'd255) begin errors++; $display("FAIL garb_saturate got=%0d exp=255", slip_cnt); end
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL garb_err_sticky got=%b exp=1", align_err); end
        relock = 1'b1;
        tick();
        relock = 1'b0;
        checks++; if ({io_reset, align_err, slip_cnt} !== {1'b1, 1'b1, 8'd255}) begin
            errors++; $display("FAIL garb_relock_keeps got=%b exp=%b", {io_reset, align_err, slip_cnt}, {1'b1, 1'b1, 8'd255});
        end
        garbage = 1'b0;
    endtask

    task automatic test_async_reset();
        int f, l;
        logic [7:0] pc;
        garbage = 1'b0; flip = 1'b0; rot = 2;
        apply_reset();
        for (int i = 0; i < 100 && pulses < 1; i++) tick();
        repeat (2) tick();
        checks++; if ({io_reset, slip_cnt} !== {1'b0, 8'd1}) begin errors++; $display("FAIL async_pre got=%b exp=%b", {io_reset, slip_cnt}, {1'b0, 8'd1}); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({io_reset, clock_enable, bitslip, locked, align_err, slip_cnt} !== {1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset_values got=%b exp=%b", {io_reset, clock_enable, bitslip, locked, align_err, slip_cnt},
                     {1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 8'h00});
        end
        rot = 0;
        apply_reset();
        run_to_lock(100, f, l, pc);
        checks++; if (f !== 16) begin errors++; $display("FAIL async_restart_fall got=%0d exp=16", f); end
        checks++; if (l !== 40) begin errors++; $display("FAIL async_restart_lock got=%0d exp=40", l); end
    endtask

    initial begin
        rstn   = 1'b0;
        relock = 1'b0;
        test_reset();
        test_aligned();
        test_rotated();
        test_err_inject();
        test_relock();
        test_garbage();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cmlink_rx_align_ctrl
`default_nettype wire
